// File: rtl/iter_muldiv_if.sv
// Request/result bundle between decode and the iterative multiply/divide unit.
// Requests are single-cycle start strobes; results are visible as HI/LO with a done pulse.
interface iter_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/iter_muldiv.sv
// Iterative radix-2 multiply/divide with HI/LO registers; MTHI/MTLO write in one cycle.
// Latency: WIDTH+1 unpaused cycles busy per mul/div; pause freezes everything; start while busy is dropped.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  iter_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state_q, state_d;
  logic   accept, mthi, mtlo;

  logic [CW-1:0]    count_q;
  logic             mul_q, neg_q, rneg_q, dz_q;
  logic [WIDTH:0]   opnd_q;
  logic [WIDTH-1:0] acc_q, shreg_q, a_raw_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dz_out_q;

  // Operand preparation for a newly accepted request
  logic           op_signed, op_mul;
  logic [WIDTH:0] a_ext, b_ext, abs_a, abs_b;

  assign op_signed = (bus.op == 3'd1) || (bus.op == 3'd3);
  assign op_mul    = (bus.op == 3'd1) || (bus.op == 3'd2);
  assign a_ext     = {op_signed & bus.a[WIDTH-1], bus.a};
  assign b_ext     = {op_signed & bus.b[WIDTH-1], bus.b};
  // One extra bit so that the magnitude of the most negative value is representable
  assign abs_a     = a_ext[WIDTH] ? -a_ext : a_ext;
  assign abs_b     = b_ext[WIDTH] ? -b_ext : b_ext;

  // One iteration step of each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic             unused_bits;

  assign mul_sum   = {1'b0, acc_q} + (shreg_q[0] ? opnd_q : '0);
  assign div_shift = {acc_q, shreg_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  // A successful trial subtraction always leaves a remainder below the divisor
  assign unused_bits = div_diff[WIDTH];

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod     = {acc_q, shreg_q};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -shreg_q : shreg_q;
  assign rem_fix  = rneg_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    mthi    = 1'b0;
    mtlo    = 1'b0;
    if (!pause) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd1, 3'd2, 3'd3, 3'd4: begin
                accept  = 1'b1;
                state_d = CALC;
              end
              3'd5:    mthi = 1'b1;
              3'd6:    mtlo = 1'b1;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (count_q == LAST) state_d = FIX;
        end
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      mul_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      shreg_q  <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else if (!pause) begin
      done_q   <= (state_q == FIX);
      dz_out_q <= (state_q == FIX) && dz_q;

      if (accept) begin
        count_q <= '0;
        mul_q   <= op_mul;
        neg_q   <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        rneg_q  <= op_signed & bus.a[WIDTH-1];
        dz_q    <= !op_mul && (bus.b == '0);
        opnd_q  <= op_mul ? abs_a : abs_b;
        acc_q   <= '0;
        shreg_q <= op_mul ? abs_b[WIDTH-1:0] : abs_a[WIDTH-1:0];
        a_raw_q <= bus.a;
      end
      if (mthi) hi_q <= bus.a;
      if (mtlo) lo_q <= bus.a;

      if (state_q == CALC) begin
        count_q <= count_q + 1'b1;
        if (mul_q) begin
          acc_q   <= mul_sum[WIDTH:1];
          shreg_q <= {mul_sum[0], shreg_q[WIDTH-1:1]};
        end else begin
          acc_q   <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          shreg_q <= {shreg_q[WIDTH-2:0], div_ok};
        end
      end

      if (state_q == FIX) begin
        if (mul_q) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (dz_q) begin
          lo_q <= '1;
          hi_q <= a_raw_q;
        end else begin
          lo_q <= quo_fix;
          hi_q <= rem_fix;
        end
      end
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.dz   = dz_out_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv: latency, signed/unsigned results, divide-by-zero, pause, MTHI/MTLO, reset abort.
module tb_iter_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pause = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  iter_muldiv_if #(.WIDTH(32)) bus ();

  iter_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .pause (pause),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one edge, then counts edges until busy falls.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  task automatic strobe(input logic [2:0] op, input logic [31:0] a);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz",   bus.dz,   0);
    check("rst_hi",   bus.hi,   0);
    check("rst_lo",   bus.lo,   0);

    // MULTU max * max
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_cycles", cyc, 33);
    check("multu_done",   bus.done, 1);
    check("multu_dz",     bus.dz, 0);
    check("multu_hi",     bus.hi, 32'hFFFF_FFFE);
    check("multu_lo",     bus.lo, 32'h0000_0001);
    tick();
    check("multu_done_clr", bus.done, 0);

    // Signed multiply and divide
    run_op(3'd1, 32'hFFFF_FFFD, 32'h0000_0007, cyc);
    check("mult_cycles", cyc, 33);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'h0000_0007, 32'hFFFF_FFFE, cyc);
    check("div_negb_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_negb_hi", bus.hi, 32'h0000_0001);

    run_op(3'd4, 32'd100, 32'd7, cyc);
    check("divu_lo", bus.lo, 32'h0000_000E);
    check("divu_hi", bus.hi, 32'h0000_0002);
    check("divu_dz", bus.dz, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0000_0000);

    // Divide by zero
    run_op(3'd4, 32'h0000_1234, 32'h0, cyc);
    check("dz_cycles", cyc, 33);
    check("dz_done",   bus.done, 1);
    check("dz_flag",   bus.dz, 1);
    check("dz_lo",     bus.lo, 32'hFFFF_FFFF);
    check("dz_hi",     bus.hi, 32'h0000_1234);
    tick();
    check("dz_flag_clr", bus.dz, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'h0, cyc);
    check("sdz_flag", bus.dz, 1);
    check("sdz_lo",   bus.lo, 32'hFFFF_FFFF);
    check("sdz_hi",   bus.hi, 32'hFFFF_FFF9);

    // Pause mid-CALC, plus an MTHI attempt while busy
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    repeat (10) begin tick(); cyc++; end
    pause = 1'b1;
    repeat (5) begin tick(); cyc++; end
    check("pause_busy", bus.busy, 1);
    check("pause_hi_hold", bus.hi, 32'hFFFF_FFF9);
    pause = 1'b0;
    strobe(3'd5, 32'hDEAD_BEEF);
    cyc++;
    while (bus.busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("pause_cycles", cyc, 38);
    check("pause_lo", bus.lo, 32'h0000_000F);
    check("pause_hi", bus.hi, 32'h0000_0000);
    // done stretches across paused cycles
    pause = 1'b1;
    tick();
    tick();
    check("done_stretch", bus.done, 1);
    pause = 1'b0;
    tick();
    check("done_after_pause", bus.done, 0);

    // MTLO / MTHI in IDLE, reserved op, start under pause
    strobe(3'd6, 32'h0000_00AA);
    check("mtlo_lo",   bus.lo, 32'h0000_00AA);
    check("mtlo_busy", bus.busy, 0);
    strobe(3'd5, 32'h1234_5678);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    strobe(3'd7, 32'h5555_5555);
    check("op7_busy", bus.busy, 0);
    check("op7_lo",   bus.lo, 32'h0000_00AA);
    pause = 1'b1;
    strobe(3'd2, 32'd9);
    pause = 1'b0;
    check("pause_start_busy", bus.busy, 0);

    // Reset aborts an operation in flight
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_hi",   bus.hi, 0);
    check("abort_lo",   bus.lo, 0);
    run_op(3'd2, 32'd6, 32'd7, cyc);
    check("post_rst_cycles", cyc, 33);
    check("post_rst_lo", bus.lo, 32'h0000_002A);
    check("post_rst_hi", bus.hi, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
